// File: rtl/xor_cipher_pkg.sv
// xor_cipher_pkg: shared FSM state type, block counter width and the tweak-forming function.
// The tweak function is only referenced when XOR_TWEAK_EN is defined.
package xor_cipher_pkg;
    localparam int BLK_CNT_W = 16;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2, DONE = 2'd3} state_t;
    function automatic logic [31:0] tweak(input logic [BLK_CNT_W-1:0] blk, input logic [15:0] idx);
        return {blk, idx};
    endfunction
endpackage

// File: rtl/xor_stream_cipher_if.sv
// xor_stream_cipher_if: control, key-write and streaming beat signals of the cipher.
interface xor_stream_cipher_if #(parameter int BLOCK_W = 512, parameter int BEAT_W = 64, parameter int KEY_SLOTS = 4);
    import xor_cipher_pkg::*;
    localparam int KS_W = KEY_SLOTS > 1 ? $clog2(KEY_SLOTS) : 1;
    logic                 start;
    logic                 abort;
    logic [KS_W-1:0]      key_sel;
    logic                 key_wr;
    logic [KS_W-1:0]      key_wr_slot;
    logic [BLOCK_W-1:0]   key_wr_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [BEAT_W-1:0]    in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [BEAT_W-1:0]    out_data;
    logic                 out_last;
    logic                 busy;
    logic                 done;
    logic [BLK_CNT_W-1:0] blk_cnt;
    modport slave (
        input  start, abort, key_sel, key_wr, key_wr_slot, key_wr_data, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, busy, done, blk_cnt
    );
    modport master (
        output start, abort, key_sel, key_wr, key_wr_slot, key_wr_data, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy, done, blk_cnt
    );
endinterface

// File: rtl/xor_stream_cipher_key_bank.sv
// xor_key_bank: KEY_SLOTS x BLOCK_W key register file; a same-cycle write to the read slot
// is forwarded so a snapshot taken on that edge sees the new key.
module xor_key_bank #(parameter int BLOCK_W = 512, parameter int KEY_SLOTS = 4,
                      localparam int KS_W = KEY_SLOTS > 1 ? $clog2(KEY_SLOTS) : 1) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_wr,
    input  logic [KS_W-1:0]    i_wr_slot,
    input  logic [BLOCK_W-1:0] i_wr_data,
    input  logic [KS_W-1:0]    i_rd_slot,
    output logic [BLOCK_W-1:0] o_rd_data
);
    logic [BLOCK_W-1:0] r_keys [KEY_SLOTS];
    logic [KS_W-1:0]    w_wr_idx, w_rd_idx;
    always_comb begin
        w_wr_idx  = 32'(i_wr_slot) < KEY_SLOTS ? i_wr_slot : '0;
        w_rd_idx  = 32'(i_rd_slot) < KEY_SLOTS ? i_rd_slot : '0;
        o_rd_data = (i_wr && w_wr_idx == w_rd_idx) ? i_wr_data : r_keys[w_rd_idx];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < KEY_SLOTS; k++) r_keys[k] <= '0;
        end else if (i_wr) begin
            r_keys[w_wr_idx] <= i_wr_data;
        end
    end
endmodule

// File: rtl/xor_stream_cipher.sv
// xor_stream_cipher: block-keyed XOR stream cipher with a one-stage beat pipeline.
// Define XOR_TWEAK_EN to also mix a {blk_cnt, beat index} tweak into every beat.
module xor_stream_cipher import xor_cipher_pkg::*; #(
    parameter int BLOCK_W   = 512,
    parameter int BEAT_W    = 64,
    parameter int KEY_SLOTS = 4
) (
    input logic clk,
    input logic rst_n,
    xor_stream_cipher_if.slave bus
);
    localparam int NBEATS = BLOCK_W / BEAT_W;
    localparam int IDX_W  = NBEATS > 1 ? $clog2(NBEATS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NBEATS - 1);
    state_t               r_state, w_state_nxt;
    logic [BLOCK_W-1:0]   r_wkey, w_sel_key, w_key_sh;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_out_valid, r_out_last;
    logic [BEAT_W-1:0]    r_out_data, w_beat;
    logic [BLK_CNT_W-1:0] r_blk_cnt;
    logic                 w_abort, w_ready, w_acc;
    xor_key_bank #(.BLOCK_W(BLOCK_W), .KEY_SLOTS(KEY_SLOTS)) u_key_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr      (bus.key_wr),
        .i_wr_slot (bus.key_wr_slot),
        .i_wr_data (bus.key_wr_data),
        .i_rd_slot (bus.key_sel),
        .o_rd_data (w_sel_key)
    );
    always_comb begin
        w_abort  = bus.abort && r_state != IDLE;
        w_ready  = r_state == RUN && (!r_out_valid || bus.out_ready);
        w_acc    = bus.in_valid && w_ready;
        w_key_sh = r_wkey << (int'(r_idx) * BEAT_W);
`ifdef XOR_TWEAK_EN
        w_beat   = bus.in_data ^ w_key_sh[BLOCK_W-1 -: BEAT_W] ^ BEAT_W'(tweak(r_blk_cnt, 16'(r_idx)));
`else
        w_beat   = bus.in_data ^ w_key_sh[BLOCK_W-1 -: BEAT_W];
`endif
        w_state_nxt = w_abort            ? IDLE :
                      r_state == IDLE    ? (bus.start ? RUN : IDLE) :
                      r_state == RUN     ? (w_acc && r_idx == LAST ? FLUSH : RUN) :
                      r_state == FLUSH   ? (r_out_valid && bus.out_ready ? DONE : FLUSH) :
                                           IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_wkey      <= '0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_blk_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && bus.start) begin
                r_wkey <= w_sel_key;
                r_idx  <= '0;
            end else if (w_acc && !w_abort) begin
                r_idx <= r_idx == LAST ? '0 : r_idx + 1'b1;
            end
            // abort wins over a beat accepted in the same cycle
            if (w_abort) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end else if (w_acc) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_beat;
                r_out_last  <= r_idx == LAST;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
            if (r_state == DONE && !bus.abort) r_blk_cnt <= r_blk_cnt + 1'b1;
        end
    end
    assign bus.in_ready  = w_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.busy      = r_state != IDLE;
    assign bus.done      = r_state == DONE;
    assign bus.blk_cnt   = r_blk_cnt;
endmodule
